// File: rtl/branch_pkg.sv
// Shared constants for the branch scheduler: opcodes, FSM states, flag bit positions.
package branch_pkg;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_C = 0;

    localparam logic [4:0] OP_GEQ = 5'b01110;
    localparam logic [4:0] OP_EQ  = 5'b01111;
    localparam logic [4:0] OP_JMP = 5'b10000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

endpackage

// File: rtl/branch_sched_condunit.sv
// Branch condition evaluation: classifies an opcode and tests it against {N,Z,V,C}.
module condunit
    import branch_pkg::*;
#(
    parameter int OPCODEWIDTH = 5
) (
    input  logic [OPCODEWIDTH-1:0] opcode,
    input  logic [3:0]             flags,
    output logic                   is_branch,
    output logic                   is_cond,
    output logic                   taken
);

    always_comb begin
        is_branch = 1'b0;
        is_cond   = 1'b0;
        taken     = 1'b0;
        if (opcode == OPCODEWIDTH'(OP_EQ)) begin
            is_branch = 1'b1;
            is_cond   = 1'b1;
            taken     = flags[FLAG_Z];
        end else if (opcode == OPCODEWIDTH'(OP_GEQ)) begin
            is_branch = 1'b1;
            is_cond   = 1'b1;
            taken     = (flags[FLAG_N] == flags[FLAG_V]);
        end else if (opcode == OPCODEWIDTH'(OP_JMP)) begin
            is_branch = 1'b1;
            taken     = 1'b1;
        end
    end

endmodule

// File: rtl/branch_sched.sv
// Branch scheduler: resolves Execute-stage branches against a flag register, stalling
// while flag-setting ops are outstanding. Optional counters under BRANCH_SCHED_STATS_EN.
//
// state    | meaning
// ST_IDLE  | accept Execute branches; resolve now or park in WAIT
// ST_WAIT  | stall pipeline until pending flag ops drain, then resolve latched branch
// ST_FLUSH | squash Decode/Execute for FLUSH_CYCLES cycles, ignore new branches
module branch_sched
    import branch_pkg::*;
#(
    parameter int OPCODEWIDTH  = 5,
    parameter int ADDR_WIDTH   = 32,
    parameter int FLUSH_CYCLES = 2,
    parameter int MAX_PENDING  = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   validE,
    input  logic [OPCODEWIDTH-1:0] opcodeE,
    input  logic [ADDR_WIDTH-1:0]  targetE,
    input  logic                   flagIssueE,
    input  logic                   flagsValid,
    input  logic [3:0]             flagsIn,
    output logic                   takeBranchE,
    output logic                   stallF,
    output logic                   stallD,
    output logic                   stallE,
    output logic                   flushD,
    output logic                   flushE,
    output logic                   pcRedirect,
    output logic [ADDR_WIDTH-1:0]  pcTarget,
    output logic                   errPending
`ifdef BRANCH_SCHED_STATS_EN
    ,
    output logic [31:0]            takenCount,
    output logic [31:0]            notTakenCount,
    output logic [31:0]            stallCount
`endif
);

    localparam int PW = $clog2(MAX_PENDING + 1);

    state_t                 state;
    logic [PW-1:0]          pending;
    logic [3:0]             flags;
    logic [OPCODEWIDTH-1:0] op_lat;
    logic [ADDR_WIDTH-1:0]  tgt_lat;
    logic [2:0]             flush_cnt;

    logic [OPCODEWIDTH-1:0] eval_op;
    logic                   br;
    logic                   cond;
    logic                   cond_taken;
    logic                   resolve;
    logic                   go_wait;
    logic                   take;
    logic                   stall;
    logic [ADDR_WIDTH-1:0]  res_target;

    // One evaluator serves both fresh Execute branches and the parked one in WAIT.
    assign eval_op = (state == ST_WAIT) ? op_lat : opcodeE;

    condunit #(
        .OPCODEWIDTH(OPCODEWIDTH)
    ) u_cond (
        .opcode   (eval_op),
        .flags    (flags),
        .is_branch(br),
        .is_cond  (cond),
        .taken    (cond_taken)
    );

    always_comb begin
        resolve    = 1'b0;
        go_wait    = 1'b0;
        res_target = targetE;
        case (state)
            ST_IDLE: begin
                if (validE && br) begin
                    if (!cond || pending == '0) resolve = 1'b1;
                    else                        go_wait = 1'b1;
                end
            end
            ST_WAIT: begin
                res_target = tgt_lat;
                if (pending == '0) resolve = 1'b1;
            end
            default: ;
        endcase
        take  = !rst && resolve && cond_taken;
        stall = !rst && (go_wait || (state == ST_WAIT && pending != '0));
    end

    assign takeBranchE = take;
    assign stallF      = stall;
    assign stallD      = stall;
    assign stallE      = stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            pending    <= '0;
            flags      <= 4'b0000;
            op_lat     <= '0;
            tgt_lat    <= '0;
            flush_cnt  <= '0;
            flushD     <= 1'b0;
            flushE     <= 1'b0;
            pcRedirect <= 1'b0;
            pcTarget   <= '0;
            errPending <= 1'b0;
        end else begin
            if (flagsValid) flags <= flagsIn;

            if (flagIssueE && !flagsValid) begin
                if (pending == PW'(MAX_PENDING)) errPending <= 1'b1;
                else                            pending    <= pending + PW'(1);
            end else if (flagsValid && !flagIssueE && pending != '0) begin
                pending <= pending - PW'(1);
            end

            pcRedirect <= take;
            if (take) pcTarget <= res_target;

            case (state)
                ST_IDLE: begin
                    if (go_wait) begin
                        op_lat  <= opcodeE;
                        tgt_lat <= targetE;
                        state   <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (resolve && !take) state <= ST_IDLE;
                end
                ST_FLUSH: begin
                    if (flush_cnt == '0) begin
                        state  <= ST_IDLE;
                        flushD <= 1'b0;
                        flushE <= 1'b0;
                    end else begin
                        flush_cnt <= flush_cnt - 3'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            if (take) begin
                state     <= ST_FLUSH;
                flush_cnt <= 3'(FLUSH_CYCLES - 1);
                flushD    <= 1'b1;
                flushE    <= 1'b1;
            end
        end
    end

`ifdef BRANCH_SCHED_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            takenCount    <= '0;
            notTakenCount <= '0;
            stallCount    <= '0;
        end else begin
            if (take)                    takenCount    <= takenCount + 32'd1;
            if (resolve && !cond_taken)  notTakenCount <= notTakenCount + 32'd1;
            if (stall)                   stallCount    <= stallCount + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_branch_sched.sv
// Testbench for branch_sched: directed scenarios plus randomized traffic vs a behavioural model.
module tb_branch_sched;

    localparam int FC   = 2;
    localparam int MAXP = 3;
    localparam int M_IDLE = 0, M_WAIT = 1, M_FLUSH = 2;

    logic        clk = 1'b0;
    logic        rst, validE, flagIssueE, flagsValid;
    logic [4:0]  opcodeE;
    logic [31:0] targetE;
    logic [3:0]  flagsIn;
    logic        takeBranchE, stallF, stallD, stallE, flushD, flushE, pcRedirect, errPending;
    logic [31:0] pcTarget;
`ifdef BRANCH_SCHED_STATS_EN
    logic [31:0] takenCount, notTakenCount, stallCount;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    branch_sched #(.OPCODEWIDTH(5), .ADDR_WIDTH(32), .FLUSH_CYCLES(FC), .MAX_PENDING(MAXP)) dut (
        .clk(clk), .rst(rst), .validE(validE), .opcodeE(opcodeE), .targetE(targetE),
        .flagIssueE(flagIssueE), .flagsValid(flagsValid), .flagsIn(flagsIn),
        .takeBranchE(takeBranchE), .stallF(stallF), .stallD(stallD), .stallE(stallE),
        .flushD(flushD), .flushE(flushE), .pcRedirect(pcRedirect), .pcTarget(pcTarget),
        .errPending(errPending)
`ifdef BRANCH_SCHED_STATS_EN
        , .takenCount(takenCount), .notTakenCount(notTakenCount), .stallCount(stallCount)
`endif
    );

    always #5 clk = ~clk;

    // Reference model state
    int          m_mode, m_pending, m_flush_left, m_op;
    bit [3:0]    m_flags;
    bit          m_err, m_redirect;
    logic [31:0] m_tgt, m_pctgt;
    bit          e_take, e_stall, e_res;
    logic [31:0] e_tgt;

    function automatic bit is_br(int op);
        return op == 14 || op == 15 || op == 16;
    endfunction

    function automatic bit cond_ok(int op, bit [3:0] f);
        if (op == 15) return f[2];
        if (op == 14) return f[3] == f[1];
        if (op == 16) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_eval();
        e_take = 0; e_stall = 0; e_res = 0; e_tgt = '0;
        if (rst) return;
        if (m_mode == M_IDLE && validE && is_br(int'(opcodeE))) begin
            if (opcodeE == 5'd16 || m_pending == 0) begin
                e_res = 1; e_take = cond_ok(int'(opcodeE), m_flags); e_tgt = targetE;
            end else e_stall = 1;
        end else if (m_mode == M_WAIT) begin
            if (m_pending > 0) e_stall = 1;
            else begin e_res = 1; e_take = cond_ok(m_op, m_flags); e_tgt = m_tgt; end
        end
    endtask

    task automatic model_update();
        if (rst) begin
            m_mode = M_IDLE; m_pending = 0; m_flush_left = 0; m_op = 0; m_flags = 0;
            m_err = 0; m_redirect = 0; m_tgt = '0; m_pctgt = '0;
            return;
        end
        m_redirect = e_take;
        if (e_take) m_pctgt = e_tgt;
        if (m_mode == M_FLUSH) begin
            m_flush_left--;
            if (m_flush_left == 0) m_mode = M_IDLE;
        end else if (e_take) begin
            m_mode = M_FLUSH; m_flush_left = FC;
        end else if (e_res) m_mode = M_IDLE;
        else if (e_stall && m_mode == M_IDLE) begin
            m_mode = M_WAIT; m_op = int'(opcodeE); m_tgt = targetE;
        end
        if (flagIssueE && !flagsValid) begin
            if (m_pending == MAXP) m_err = 1; else m_pending++;
        end else if (flagsValid && !flagIssueE && m_pending > 0) m_pending--;
        if (flagsValid) m_flags = flagsIn;
    endtask

    task automatic drive(input bit v, input int op, input logic [31:0] tgt,
                         input bit iss, input bit fv, input bit [3:0] fin, input bit r);
        validE = v; opcodeE = 5'(op); targetE = tgt;
        flagIssueE = iss; flagsValid = fv; flagsIn = fin; rst = r;
        #1;
        model_eval();
    endtask

    task automatic tick();
        @(posedge clk);
        model_eval();
        model_update();
        @(negedge clk);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin drive(0, 0, 0, 0, 0, 0, 0); tick(); end
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 0, 1); tick();
        drive(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        drive(0, 0, 0, 0, 0, 0, 1); tick(); tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        n_checks++;
        if ({takeBranchE, stallF, stallD, stallE, flushD, flushE, pcRedirect, errPending} !== 8'h00) begin
            n_fail++; $display("FAIL reset_outputs: got %b want 00000000",
                {takeBranchE, stallF, stallD, stallE, flushD, flushE, pcRedirect, errPending});
        end
        n_checks++;
        if (pcTarget !== 32'h0) begin n_fail++; $display("FAIL reset_pctarget: got %h want 0", pcTarget); end
    endtask

    task automatic test_eq_taken();
        do_reset();
        drive(0, 0, 0, 0, 1, 4'b0100, 0); tick();
        drive(1, 15, 32'h40, 0, 0, 0, 0);
        n_checks++;
        if (takeBranchE !== 1'b1 || stallE !== 1'b0) begin
            n_fail++; $display("FAIL eq_take: take=%b stall=%b want take=1 stall=0", takeBranchE, stallE);
        end
        tick(); drive(0, 0, 0, 0, 0, 0, 0);
        n_checks++;
        if (pcRedirect !== 1'b1 || pcTarget !== 32'h40 || flushD !== 1'b1 || flushE !== 1'b1) begin
            n_fail++; $display("FAIL eq_redirect: redir=%b tgt=%h flush=%b%b want 1 00000040 11",
                pcRedirect, pcTarget, flushD, flushE);
        end
        tick();
        n_checks++;
        if (pcRedirect !== 1'b0 || flushD !== 1'b1 || flushE !== 1'b1) begin
            n_fail++; $display("FAIL eq_flush2: redir=%b flush=%b%b want 0 11", pcRedirect, flushD, flushE);
        end
        tick();
        n_checks++;
        if (flushD !== 1'b0 || flushE !== 1'b0) begin
            n_fail++; $display("FAIL eq_flush_end: flush=%b%b want 00", flushD, flushE);
        end
    endtask

    task automatic test_geq_stall();
        do_reset();
        drive(0, 0, 0, 1, 0, 0, 0); tick();
        drive(1, 14, 32'h55, 0, 0, 0, 0);
        n_checks++;
        if ({stallF, stallD, stallE} !== 3'b111 || takeBranchE !== 1'b0) begin
            n_fail++; $display("FAIL geq_stall: stalls=%b take=%b want 111 0", {stallF, stallD, stallE}, takeBranchE);
        end
        tick();
        for (int i = 0; i < 2; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0);
            n_checks++;
            if (stallE !== 1'b1) begin n_fail++; $display("FAIL geq_hold: stall=%b want 1 (cycle %0d)", stallE, i); end
            tick();
        end
        drive(0, 0, 0, 0, 1, 4'b1000, 0);
        n_checks++;
        if (stallE !== 1'b1) begin n_fail++; $display("FAIL geq_hold_fv: stall=%b want 1", stallE); end
        tick(); drive(0, 0, 0, 0, 0, 0, 0);
        n_checks++;
        if ({stallF, stallD, stallE} !== 3'b000 || takeBranchE !== 1'b0) begin
            n_fail++; $display("FAIL geq_release: stalls=%b take=%b want 000 0", {stallF, stallD, stallE}, takeBranchE);
        end
        tick();
        n_checks++;
        if (flushD !== 1'b0 || pcRedirect !== 1'b0) begin
            n_fail++; $display("FAIL geq_noflush: flush=%b redir=%b want 0 0", flushD, pcRedirect);
        end
    endtask

    task automatic test_jmp_pending();
        do_reset();
        drive(0, 0, 0, 1, 0, 0, 0); tick(); tick();
        drive(1, 16, 32'h80, 0, 0, 0, 0);
        n_checks++;
        if (takeBranchE !== 1'b1 || stallE !== 1'b0) begin
            n_fail++; $display("FAIL jmp_take: take=%b stall=%b want 1 0", takeBranchE, stallE);
        end
        tick(); drive(0, 0, 0, 0, 0, 0, 0);
        n_checks++;
        if (pcRedirect !== 1'b1 || pcTarget !== 32'h80) begin
            n_fail++; $display("FAIL jmp_redirect: redir=%b tgt=%h want 1 00000080", pcRedirect, pcTarget);
        end
        idle_cycles(3);
    endtask

    task automatic test_pending();
        do_reset();
        drive(0, 0, 0, 1, 0, 0, 0); tick();
        drive(0, 0, 0, 1, 1, 4'b0000, 0); tick();
        drive(1, 14, 32'h10, 0, 0, 0, 0);
        n_checks++;
        if (stallE !== 1'b1) begin n_fail++; $display("FAIL pend_same_cycle: stall=%b want 1", stallE); end
        tick();
        drive(0, 0, 0, 0, 1, 4'b0000, 0); tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        n_checks++;
        if (stallE !== 1'b0 || takeBranchE !== 1'b1) begin
            n_fail++; $display("FAIL pend_drain: stall=%b take=%b want 0 1", stallE, takeBranchE);
        end
        idle_cycles(4);
        do_reset();
        for (int i = 0; i < 3; i++) begin drive(0, 0, 0, 1, 0, 0, 0); tick(); end
        n_checks++;
        if (errPending !== 1'b0) begin n_fail++; $display("FAIL pend_no_err: err=%b want 0", errPending); end
        drive(0, 0, 0, 1, 0, 0, 0); tick();
        n_checks++;
        if (errPending !== 1'b1) begin n_fail++; $display("FAIL pend_overflow: err=%b want 1", errPending); end
        for (int i = 0; i < 2; i++) begin drive(0, 0, 0, 0, 1, 4'b0100, 0); tick(); end
        drive(1, 15, 32'h20, 0, 0, 0, 0);
        n_checks++;
        if (stallE !== 1'b1) begin n_fail++; $display("FAIL pend_sat_one_left: stall=%b want 1", stallE); end
        tick();
        drive(0, 0, 0, 0, 1, 4'b0100, 0); tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        n_checks++;
        if (stallE !== 1'b0 || takeBranchE !== 1'b1 || errPending !== 1'b1) begin
            n_fail++; $display("FAIL pend_sat_drain: stall=%b take=%b err=%b want 0 1 1", stallE, takeBranchE, errPending);
        end
        idle_cycles(4);
    endtask

    task automatic test_reset_midflight();
        do_reset();
        drive(0, 0, 0, 1, 0, 0, 0); tick();
        drive(1, 15, 32'h30, 0, 0, 0, 0); tick();
        drive(0, 0, 0, 0, 0, 0, 1); tick();
        drive(1, 15, 32'h31, 0, 0, 0, 0);
        n_checks++;
        if ({takeBranchE, stallE, flushD, flushE, pcRedirect, errPending} !== 6'b0 || pcTarget !== 32'h0) begin
            n_fail++; $display("FAIL rst_in_wait: outs=%b tgt=%h want 000000 0",
                {takeBranchE, stallE, flushD, flushE, pcRedirect, errPending}, pcTarget);
        end
        tick();
        drive(0, 0, 0, 0, 1, 4'b0100, 0); tick();
        drive(1, 16, 32'h90, 0, 0, 0, 0); tick();
        drive(0, 0, 0, 0, 0, 0, 1);
        n_checks++;
        if (flushD !== 1'b1) begin n_fail++; $display("FAIL rst_flush_setup: flush=%b want 1", flushD); end
        tick(); drive(0, 0, 0, 0, 0, 0, 0);
        n_checks++;
        if ({takeBranchE, stallE, flushD, flushE, pcRedirect, errPending} !== 6'b0 || pcTarget !== 32'h0) begin
            n_fail++; $display("FAIL rst_in_flush: outs=%b tgt=%h want 000000 0",
                {takeBranchE, stallE, flushD, flushE, pcRedirect, errPending}, pcTarget);
        end
    endtask

    task automatic test_flush_ignore();
        do_reset();
        drive(0, 0, 0, 0, 1, 4'b0100, 0); tick();
        drive(1, 15, 32'h44, 0, 0, 0, 0); tick();
        for (int i = 0; i < FC; i++) begin
            drive(1, 15, 32'hA0 + i, 0, 0, 0, 0);
            n_checks++;
            if (takeBranchE !== 1'b0 || flushE !== 1'b1) begin
                n_fail++; $display("FAIL flush_ignore: take=%b flush=%b want 0 1 (cycle %0d)", takeBranchE, flushE, i);
            end
            tick();
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        n_checks++;
        if (pcTarget !== 32'h44 || flushE !== 1'b0) begin
            n_fail++; $display("FAIL flush_ignore_tgt: tgt=%h flush=%b want 00000044 0", pcTarget, flushE);
        end
    endtask

    task automatic test_random();
        int op;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            case ($urandom_range(0, 3))
                0: op = 14;
                1: op = 15;
                2: op = 16;
                default: op = int'($urandom_range(0, 31));
            endcase
            drive($urandom_range(0, 1), op, $urandom, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 3) == 0, 4'($urandom), $urandom_range(0, 99) == 0);
            n_checks++;
            if ({takeBranchE, stallF, stallD, stallE} !== {e_take, e_stall, e_stall, e_stall}) begin
                n_fail++; $display("FAIL rnd_comb c=%0d: got %b want %b", c,
                    {takeBranchE, stallF, stallD, stallE}, {e_take, e_stall, e_stall, e_stall});
            end
            n_checks++;
            if ({flushD, flushE, pcRedirect, errPending} !==
                {m_mode == M_FLUSH, m_mode == M_FLUSH, m_redirect, m_err}) begin
                n_fail++; $display("FAIL rnd_reg c=%0d: got %b want %b", c,
                    {flushD, flushE, pcRedirect, errPending},
                    {m_mode == M_FLUSH, m_mode == M_FLUSH, m_redirect, m_err});
            end
            n_checks++;
            if (pcTarget !== m_pctgt) begin
                n_fail++; $display("FAIL rnd_pctarget c=%0d: got %h want %h", c, pcTarget, m_pctgt);
            end
            tick();
        end
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0, 1);
        test_reset();
        test_eq_taken();
        test_geq_stall();
        test_jmp_pending();
        test_pending();
        test_reset_midflight();
        test_flush_ignore();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
